// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM
// encoding and the default confirmation window.
package debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_APERTO = 2'd1,
    APERTADO    = 2'd2,
    CONF_SOLTO  = 2'd3
  } estado_t;

  // Debounced level: high while pressed or while a release is still unconfirmed.
  function automatic logic nivel_estavel(input estado_t estado);
    return (estado == APERTADO) || (estado == CONF_SOLTO);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button channel: 2-flop synchronizer, 4-state confirmation FSM with a
// saturating-free counter, a press strobe and a registered debounced level.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic aceito,
  output logic estavel
);

  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  estado_t          estado_r;
  estado_t          estado_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             aceito_s;
  logic             estavel_r;

  // Synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // State, counter and level registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_r  <= SOLTO;
      cnt_r     <= '0;
      estavel_r <= 1'b0;
    end else begin
      estado_r  <= estado_next_s;
      cnt_r     <= cnt_next_s;
      estavel_r <= nivel_estavel(estado_next_s);
    end
  end

  // Next state; the counter restarts on every state change so it never wraps.
  always_comb begin
    estado_next_s = estado_r;
    cnt_next_s    = '0;
    aceito_s      = 1'b0;
    case (estado_r)
      SOLTO: begin
        if (sync2_r) begin
          estado_next_s = CONF_APERTO;
        end else begin
          estado_next_s = SOLTO;
        end
      end
      CONF_APERTO: begin
        if (!sync2_r) begin
          estado_next_s = SOLTO;
        end else if (cnt_r == CNT_FIM) begin
          estado_next_s = APERTADO;
          aceito_s      = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      APERTADO: begin
        if (!sync2_r) begin
          estado_next_s = CONF_SOLTO;
        end else begin
          estado_next_s = APERTADO;
        end
      end
      CONF_SOLTO: begin
        if (sync2_r) begin
          estado_next_s = APERTADO;
        end else if (cnt_r == CNT_FIM) begin
          estado_next_s = SOLTO;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        estado_next_s = SOLTO;
      end
    endcase
  end

  assign aceito  = aceito_s;
  assign estavel = estavel_r;

endmodule

// File: rtl/debounce_botoes.sv
// Eight independent debounced push-button channels producing single-cycle
// press pulses (gated by habilita) and debounced levels, all registered.
module debounce_botoes
  import debounce_pkg::*;
#(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] botoes_raw,
  input  logic         habilita,
  output logic [N-1:0] botoes,
  output logic [N-1:0] botoes_estavel
);

  logic [N-1:0] aceito_s;
  logic [N-1:0] botoes_r;

  for (genvar i = 0; i < N; i++) begin : g_canal
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .raw     (botoes_raw[i]),
      .aceito  (aceito_s[i]),
      .estavel (botoes_estavel[i])
    );
  end

  // Pulse register; habilita is sampled in the transition cycle, so a
  // suppressed press is simply lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      botoes_r <= '0;
    end else begin
      botoes_r <= aceito_s & {N{habilita}};
    end
  end

  assign botoes = botoes_r;

endmodule
